// File: rtl/riscv_pkg.sv
// Shared RV32I encoding constants: instruction formats, opcodes, NOP and loader states.
package riscv_pkg;

  // Same 3-bit codes as the control unit's immediate-type selector
  typedef enum logic [2:0] {
    FMT_R = 3'b000,
    FMT_I = 3'b001,
    FMT_S = 3'b010,
    FMT_B = 3'b011,
    FMT_J = 3'b100,
    FMT_U = 3'b101
  } fmt_e;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [31:0] RV_NOP = 32'h00000013;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCEPT = 2'd1;
  localparam logic [1:0] ST_WRITE  = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

endpackage

// File: rtl/instr_field_packer.sv
// Combinational RV32I field packer: decoded fields + format -> 32-bit instruction word.
module instr_field_packer
  import riscv_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        illegal,
  output logic        misaligned
);

  // Bit-exact packing; B/J drop imm[0] by construction, flagged as misaligned
  always_comb begin
    word       = RV_NOP;
    illegal    = 1'b0;
    misaligned = 1'b0;
    case (fmt)
      FMT_R: word = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I: word = {imm[11:0], rs1, funct3, rd, opcode};
      FMT_S: word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_B: begin
        word       = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        misaligned = imm[0];
      end
      FMT_J: begin
        word       = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        misaligned = imm[0];
      end
      FMT_U: word = {imm[31:12], rd, opcode};
      default: begin
        word    = RV_NOP;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Instruction encoder and memory loader: accepts field bundles, packs them and writes
// them to consecutive instruction-memory words, one load session per start.
module instr_encoder_loader
  import riscv_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W:0] COUNT_FULL = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] COUNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [1:0]        state_r;
  logic              armed_r;
  logic              last_r;
  logic              err_r;
  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W:0]   count_r;
  logic [ADDR_W-1:0] imem_addr_r;
  logic [31:0]       imem_wdata_r;
  logic [ADDR_W:0]   count_next_s;
  logic [31:0]       pk_word_s;
  logic              pk_illegal_s;
  logic              pk_misaligned_s;

  instr_field_packer u_packer (
    .fmt        (in_fmt),
    .opcode     (in_opcode),
    .rd         (in_rd),
    .rs1        (in_rs1),
    .rs2        (in_rs2),
    .funct3     (in_funct3),
    .funct7     (in_funct7),
    .imm        (in_imm),
    .word       (pk_word_s),
    .illegal    (pk_illegal_s),
    .misaligned (pk_misaligned_s)
  );

  assign count_next_s = count_r + COUNT_ONE;

  // Session FSM; armed_r blocks a start seen on the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      armed_r      <= 1'b0;
      last_r       <= 1'b0;
      err_r        <= 1'b0;
      addr_r       <= BASE_ADDR;
      count_r      <= '0;
      imem_addr_r  <= BASE_ADDR;
      imem_wdata_r <= 32'h00000000;
    end else begin
      armed_r <= 1'b1;
      case (state_r)
        ST_IDLE: begin
          if (start && armed_r) begin
            state_r <= ST_ACCEPT;
            addr_r  <= BASE_ADDR;
            count_r <= '0;
            err_r   <= 1'b0;
          end
        end
        ST_ACCEPT: begin
          if (in_valid) begin
            imem_addr_r  <= addr_r;
            imem_wdata_r <= pk_word_s;
            last_r       <= in_last;
            if (pk_illegal_s || pk_misaligned_s) begin
              err_r <= 1'b1;
            end
            state_r <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          count_r <= count_next_s;
          addr_r  <= addr_r + ADDR_ONE;
          // Memory full without a last marker ends the session rather than wrapping
          if (last_r || (count_next_s == COUNT_FULL)) begin
            state_r <= ST_FINISH;
            if (!last_r) begin
              err_r <= 1'b1;
            end
          end else begin
            state_r <= ST_ACCEPT;
          end
        end
        ST_FINISH: state_r <= ST_IDLE;
        default:   state_r <= ST_IDLE;
      endcase
    end
  end

  assign in_ready   = (state_r == ST_ACCEPT);
  assign imem_we    = (state_r == ST_WRITE);
  assign busy       = (state_r == ST_ACCEPT) || (state_r == ST_WRITE);
  assign done       = (state_r == ST_FINISH);
  assign err        = err_r;
  assign count      = count_r;
  assign imem_addr  = imem_addr_r;
  assign imem_wdata = imem_wdata_r;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench for instr_encoder_loader: a default-size instance for encoding and
// session behaviour, and an ADDR_W=2 instance for the memory-full boundary.
module tb_instr_encoder_loader;
  import riscv_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Main instance signals
  logic        rst_n = 1'b0, start = 1'b0, in_valid = 1'b0, in_last = 1'b0;
  logic [2:0]  in_fmt = 3'd0, in_funct3 = 3'd0;
  logic [6:0]  in_opcode = 7'd0, in_funct7 = 7'd0;
  logic [4:0]  in_rd = 5'd0, in_rs1 = 5'd0, in_rs2 = 5'd0;
  logic [31:0] in_imm = 32'd0;
  logic        in_ready, imem_we, busy, done, err;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [10:0] count;

  // Small instance signals
  logic        start2 = 1'b0, in_valid2 = 1'b0;
  logic [4:0]  in_rd2 = 5'd0;
  logic [31:0] in_imm2 = 32'd0;
  logic        in_ready2, imem_we2, busy2, done2, err2;
  logic [1:0]  imem_addr2;
  logic [31:0] imem_wdata2;
  logic [2:0]  count2;

  instr_encoder_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .in_last(in_last), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .err(err), .count(count)
  );

  instr_encoder_loader #(.ADDR_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_fmt(3'b001), .in_opcode(7'b0010011), .in_rd(in_rd2), .in_rs1(5'd0),
    .in_rs2(5'd0), .in_funct3(3'd0), .in_funct7(7'd0), .in_imm(in_imm2),
    .in_last(1'b0), .imem_we(imem_we2), .imem_addr(imem_addr2), .imem_wdata(imem_wdata2),
    .busy(busy2), .done(done2), .err(err2), .count(count2)
  );

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  exp_t e1, e2;
  int   wr_cyc[$];
  int   writes2 = 0;
  int   checks = 0;
  int   errors = 0;
  logic [9:0] exp_addr = 10'd0;

  // Scoreboard for the main instance
  always @(negedge clk) begin
    if (imem_we) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL write_unexpected got addr=%0d data=%h, required no write", imem_addr, imem_wdata);
      end else begin
        e1 = q1.pop_front();
        if (imem_addr !== e1.addr || imem_wdata !== e1.data) begin
          errors++;
          $display("FAIL write_data got addr=%0d data=%h, required addr=%0d data=%h",
                   imem_addr, imem_wdata, e1.addr, e1.data);
        end
      end
      wr_cyc.push_back(cyc);
    end
  end

  // Scoreboard for the small instance
  always @(negedge clk) begin
    if (imem_we2) begin
      checks++;
      writes2++;
      if (q2.size() == 0) begin
        errors++;
        $display("FAIL write2_unexpected got addr=%0d data=%h, required no write", imem_addr2, imem_wdata2);
      end else begin
        e2 = q2.pop_front();
        if ({8'd0, imem_addr2} !== e2.addr || imem_wdata2 !== e2.data) begin
          errors++;
          $display("FAIL write2_data got addr=%0d data=%h, required addr=%0d data=%h",
                   imem_addr2, imem_wdata2, e2.addr, e2.data);
        end
      end
    end
  end

  task automatic start_session();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    exp_addr = 10'd0;
  endtask

  // Drive one bundle, push its expected write, and return once it is taken (or timed out)
  task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] imm, input logic last,
                      input logic [31:0] exp_word, input logic drop, output logic accepted);
    int n = 0;
    in_fmt = fmt; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_last = last; in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    accepted = in_ready;
    if (accepted) begin
      q1.push_back('{addr: exp_addr, data: exp_word});
      exp_addr = exp_addr + 10'd1;
    end
    @(posedge clk); #1;
    if (drop) in_valid = 1'b0;
  endtask

  task automatic wait_done(output logic seen, output int dcyc);
    int n = 0;
    seen = 1'b0;
    dcyc = -1;
    while (!seen && n < 20) begin
      if (done) begin
        seen = 1'b1;
        dcyc = cyc;
      end else begin
        @(posedge clk); #1;
        n++;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, imem_we, busy, done, err} !== 5'b00000 || count !== 11'd0 ||
        imem_addr !== 10'd0 || imem_wdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_values got rdy/we/busy/done/err=%b count=%0d addr=%0d wdata=%h, required 00000/0/0/0",
               {in_ready, imem_we, busy, done, err}, count, imem_addr, imem_wdata);
    end
    rst_n = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL start_at_reset_release got busy=%b, required 0", busy);
    end
  endtask

  task automatic test_single();
    logic acc, seen;
    int dcyc;
    start_session();
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1 || count !== 11'd0) begin
      errors++;
      $display("FAIL session_start got busy=%b rdy=%b count=%0d, required 1/1/0", busy, in_ready, count);
    end
    send(3'b001, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1, 32'h00500093, 1'b1, acc);
    wait_done(seen, dcyc);
    checks++;
    if (!acc || !seen || dcyc !== wr_cyc[$] + 1) begin
      errors++;
      $display("FAIL single_done got acc=%b done=%b dcyc=%0d, required 1/1/%0d", acc, seen, dcyc, wr_cyc[$] + 1);
    end
    checks++;
    if (count !== 11'd1 || err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_status got count=%0d err=%b busy=%b, required 1/0/0", count, err, busy);
    end
  endtask

  task automatic test_stream();
    logic a0, a1, a2, seen;
    int dcyc, base;
    base = wr_cyc.size();
    start_session();
    send(3'b000, OP_REG,   5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0,       1'b0, 32'h002081B3, 1'b0, a0);
    send(3'b010, OP_STORE, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd12,      1'b0, 32'h0020A623, 1'b0, a1);
    send(3'b101, OP_LUI,   5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 1'b1, 32'h123452B7, 1'b1, a2);
    wait_done(seen, dcyc);
    checks++;
    if (!(a0 && a1 && a2 && seen) || count !== 11'd3) begin
      errors++;
      $display("FAIL stream_status got acc=%b%b%b done=%b count=%0d, required 1111/3", a0, a1, a2, seen, count);
    end
    checks++;
    if (wr_cyc.size() !== base + 3 || wr_cyc[base + 1] - wr_cyc[base] !== 2 ||
        wr_cyc[base + 2] - wr_cyc[base + 1] !== 2) begin
      errors++;
      $display("FAIL stream_spacing got %0d writes, required 3 writes 2 cycles apart", wr_cyc.size() - base);
    end
  endtask

  task automatic test_branch_jump();
    logic a0, a1, a2, seen;
    int dcyc;
    start_session();
    send(3'b011, OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8,    1'b0, 32'h00208463, 1'b0, a0);
    send(3'b100, OP_JAL,    5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b0, 32'h001000EF, 1'b0, a1);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL aligned_err got err=%b, required 0", err);
    end
    send(3'b100, OP_JAL,    5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3,    1'b1, 32'h002000EF, 1'b1, a2);
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL misaligned_err got err=%b, required 1", err);
    end
    wait_done(seen, dcyc);
    checks++;
    if (!(a0 && a1 && a2 && seen) || count !== 11'd3) begin
      errors++;
      $display("FAIL bj_status got acc=%b%b%b done=%b count=%0d, required 1111/3", a0, a1, a2, seen, count);
    end
  endtask

  task automatic test_illegal();
    logic a0, a1, seen;
    int dcyc;
    start_session();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear_on_start got err=%b, required 0", err);
    end
    send(3'b111, OP_REG, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b1, RV_NOP, 1'b1, a0);
    wait_done(seen, dcyc);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (!a0 || !seen || err !== 1'b1) begin
      errors++;
      $display("FAIL illegal_err got acc=%b done=%b err=%b, required 1/1/1", a0, seen, err);
    end
    checks++;
    if (imem_addr !== 10'd0 || imem_wdata !== RV_NOP || imem_we !== 1'b0) begin
      errors++;
      $display("FAIL hold_outputs got addr=%0d wdata=%h we=%b, required 0/%h/0", imem_addr, imem_wdata, imem_we, RV_NOP);
    end
    start_session();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_sticky_clear got err=%b, required 0", err);
    end
    send(3'b000, OP_REG, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b1, 32'h002081B3, 1'b1, a1);
    wait_done(seen, dcyc);
  endtask

  task automatic test_overflow();
    int k = 0;
    int n = 0;
    logic hs, seen = 1'b0, ready_late = 1'b0;
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    in_rd2 = 5'd1; in_imm2 = 32'd0; in_valid2 = 1'b1;
    while (!seen && n < 40) begin
      hs = in_ready2;
      if (hs) q2.push_back('{addr: 10'(k), data: {12'(k), 5'd0, 3'd0, 5'(k + 1), 7'b0010011}});
      @(posedge clk); #1;
      n++;
      if (hs) begin
        k++;
        in_rd2 = 5'(k + 1);
        in_imm2 = 32'(k);
      end
      if (done2) seen = 1'b1;
    end
    repeat (4) begin
      @(posedge clk); #1;
      if (in_ready2) ready_late = 1'b1;
    end
    in_valid2 = 1'b0;
    checks++;
    if (k !== 4 || writes2 !== 4 || ready_late !== 1'b0) begin
      errors++;
      $display("FAIL overflow_accepts got accepted=%0d writes=%0d late_ready=%b, required 4/4/0", k, writes2, ready_late);
    end
    checks++;
    if (!seen || err2 !== 1'b1 || count2 !== 3'd4 || busy2 !== 1'b0) begin
      errors++;
      $display("FAIL overflow_status got done=%b err=%b count=%0d busy=%b, required 1/1/4/0", seen, err2, count2, busy2);
    end
  endtask

  task automatic test_reset_mid();
    logic acc, seen, done_seen = 1'b0;
    int n = 0;
    int dcyc;
    start_session();
    in_fmt = 3'b001; in_opcode = OP_IMM; in_rd = 5'd7; in_rs1 = 5'd0;
    in_imm = 32'd9; in_last = 1'b0; in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    checks++;
    if (imem_we !== 1'b1) begin
      errors++;
      $display("FAIL mid_write_reached got we=%b, required 1", imem_we);
    end
    #1 rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++;
    if ({in_ready, imem_we, busy, done, err} !== 5'b00000 || count !== 11'd0 ||
        imem_addr !== 10'd0 || imem_wdata !== 32'd0) begin
      errors++;
      $display("FAIL mid_reset_values got rdy/we/busy/done/err=%b count=%0d addr=%0d wdata=%h, required 00000/0/0/0",
               {in_ready, imem_we, busy, done, err}, count, imem_addr, imem_wdata);
    end
    repeat (3) begin
      @(posedge clk); #1;
      if (done) done_seen = 1'b1;
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    if (done) done_seen = 1'b1;
    checks++;
    if (done_seen !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_done got done pulse, required none");
    end
    start_session();
    send(3'b001, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1, 32'h00500093, 1'b1, acc);
    wait_done(seen, dcyc);
    checks++;
    if (!acc || !seen || count !== 11'd1) begin
      errors++;
      $display("FAIL resume_after_reset got acc=%b done=%b count=%0d, required 1/1/1", acc, seen, count);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_branch_jump();
    test_illegal();
    test_overflow();
    test_reset_mid();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (q1.size() !== 0 || q2.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d/%0d pending writes, required 0/0", q1.size(), q2.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_encoder_loader.md
# instr_encoder_loader

Sequential RISC-V RV32I instruction encoder and instruction-memory loader. Accepts decoded instruction fields over a valid/ready handshake, packs them into 32-bit instruction words, and writes them to consecutive instruction-memory locations. It performs the inverse of opcode decoding. It sits beside instruction memory as the boot/program-load path and as a self-checking stimulus source for the pipeline.

## Interface
- ADDR_W, 10, instruction-memory word-address width
- BASE_ADDR, 0, first word address written in each session
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  begin a load session; ignored unless idle
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder accepts bundle this cycle
- in_fmt  in  3  format: 000 R, 001 I, 010 S, 011 B, 100 J, 101 U; 110/111 illegal
- in_opcode  in  7  opcode field
- in_rd, in_rs1, in_rs2  in  5 each  register fields
- in_funct3  in  3, in_funct7  in  7  function fields
- in_imm  in  32  immediate, byte offset (B/J) or full value (U uses imm[31:12])
- in_last  in  1  final instruction of session
- imem_we  out  1  instruction-memory write strobe
- imem_addr  out  ADDR_W  word address
- imem_wdata  out  32  encoded instruction
- busy  out  1  session in progress
- done  out  1  one-cycle pulse at session end
- err  out  1  sticky error, cleared by next accepted start
- count  out  ADDR_W+1  words written this session

## Operation
- States: IDLE, ACCEPT, WRITE, FINISH.
- IDLE: start -> ACCEPT; addr := BASE_ADDR, count := 0, err := 0.
- ACCEPT: in_ready=1; on in_valid&in_ready register encoded word and in_last -> WRITE.
- WRITE: imem_we=1 for exactly one cycle with current addr/wdata; count+1; addr+1 (mod 2^ADDR_W). Next: FINISH if last registered or count reaches 2^ADDR_W, else ACCEPT.
- FINISH: done=1 one cycle -> IDLE.
- Packing (bit-exact RV32I):
  - R = funct7|rs2|rs1|funct3|rd|opcode
  - I = imm[11:0]|rs1|funct3|rd|opcode
  - S = imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode
  - B = imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode
  - J = imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode
  - U = imm[31:12]|rd|opcode
- Unused imm high bits are silently truncated.
- Illegal fmt: write NOP 0x00000013 in its place; set err.
- B/J with imm[0]=1: imm[0] dropped, word written, err set.
- Overflow: after 2^ADDR_W writes without in_last, set err and end the session. No wrap-overwrite.

## Timing
- Reset values: in_ready 0, imem_we 0, imem_addr BASE_ADDR, imem_wdata 0, busy 0, done 0, err 0, count 0; state IDLE.
- Reset asserted mid-session: immediate return to IDLE. No partial write, no done pulse.
- busy=1 in ACCEPT and WRITE, 0 in IDLE and FINISH.
- Latency:
  - handshake edge -> imem_we next cycle.
  - throughput 1 word per 2 cycles max.
  - done 1 cycle after last write.
- in_ready is registered-state decode only, with no combinational path from in_valid. Fields sampled only on handshake edge.
- start during busy or FINISH: ignored. start and rst_n release in same cycle: start ignored.
- imem_addr/imem_wdata hold their last values outside WRITE.

## Structure
- Shared riscv_pkg holds:
  - fmt_e enum, with the same 3-bit codes as the control unit's immediate-type selector
  - opcode constants
  - RV_NOP = 32'h00000013
  - loader state enum
- Sub-module instr_field_packer: purely combinational fields+fmt -> {word, illegal, misaligned}. Reusable by testbench reference model.

## Test plan
- start; addi x1,x0,5 (I, 0010011, imm 5, last) -> imem_we at addr 0, wdata 0x00500093, count 1, done pulse, err 0.
- Stream add x3,x1,x2 (R, 0110011); sw x2,12(x1) (S, funct3 010); lui x5,0x12345 (U, last) -> addrs 0,1,2 with 0x002081B3, 0x0020A623, 0x123452B7; in_valid held high gives 2-cycle spacing.
- beq x1,x2,+8 (B, 1100011) -> 0x00208463; jal x1,+2048 (J, 1101111) -> 0x001000EF; jal with imm 3 -> imm[0] dropped, err=1.
- in_fmt=111 -> wdata 0x00000013 written, err stays 1 until next start.
- ADDR_W=2, five bundles without last -> exactly 4 writes at addrs 0..3, err=1, done pulse, fifth bundle never accepted.
- rst_n low during WRITE -> imem_we 0 immediately, all outputs at reset values; new start resumes at BASE_ADDR.
